// File: rtl/cmul_pkg.sv
// Shared widths, scale helpers and rounding-mode constants for the complex multiplier.
package cmul_pkg;

    typedef enum logic {
        RND_TRUNC = 1'b0,
        RND_NEAR  = 1'b1
    } rnd_mode_e;

    function automatic int prod_w(input int in_w, input int tw_w);
        return in_w + tw_w;
    endfunction

    function automatic int sum_w(input int in_w, input int tw_w);
        return in_w + tw_w + 1;
    endfunction

    function automatic int scale_sh(input int in_frac, input int tw_frac, input int out_frac);
        return in_frac + tw_frac - out_frac;
    endfunction

endpackage

// File: rtl/cmul_if.sv
// Sample/twiddle input stream and result output stream of the complex multiplier.
interface cmul_if #(
    parameter int IN_W  = 8,
    parameter int TW_W  = 12,
    parameter int OUT_W = 13
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  in_r;
    logic signed [IN_W-1:0]  in_i;
    logic signed [TW_W-1:0]  cos_tw;
    logic signed [TW_W-1:0]  sin_tw;
    logic                    conj_i;
    logic                    rnd_i;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_r;
    logic signed [OUT_W-1:0] out_i;
    logic                    sat_o;
    logic                    sat_sticky;

    modport master (
        output in_valid, in_r, in_i, cos_tw, sin_tw, conj_i, rnd_i, out_ready,
        input  in_ready, out_valid, out_r, out_i, sat_o, sat_sticky
    );

    modport slave (
        input  in_valid, in_r, in_i, cos_tw, sin_tw, conj_i, rnd_i, out_ready,
        output in_ready, out_valid, out_r, out_i, sat_o, sat_sticky
    );
endinterface

// File: rtl/cmul_round_sat.sv
// Scale by 2^-SH with sign-magnitude truncate or round-half-away, then clamp to OUT_W.
// Latency: combinational (0 cycles).
// Backpressure: none; pure function of its inputs.
module cmul_round_sat
    import cmul_pkg::*;
#(
    parameter int IN_W  = 21,
    parameter int SH    = 5,
    parameter int OUT_W = 13
) (
    input  logic signed [IN_W-1:0]  x,
    input  logic                    rnd,
    output logic signed [OUT_W-1:0] y,
    output logic                    sat
);
    // Two spare bits: negating the most negative input and adding the half LSB never wrap.
    localparam int MW = IN_W + 2;
    localparam logic signed [MW:0] MAXV = (MW+1)'((1 << (OUT_W-1)) - 1);
    localparam logic signed [MW:0] MINV = ~MAXV;

    logic          neg;
    logic [MW-1:0] mag;
    logic [MW-1:0] q;
    logic signed [MW:0] val;

    assign neg = x[IN_W-1];
    assign mag = neg ? (MW'(0) - MW'(x)) : MW'(x);

    generate
        if (SH > 0) begin : g_scale
            localparam logic [MW-1:0] HALF = MW'(1) << (SH-1);
            logic [MW-1:0] mag_rnd;
            assign mag_rnd = mag + ((rnd == RND_NEAR) ? HALF : '0);
            assign q       = mag_rnd >> SH;
        end else begin : g_exact
            logic unused_rnd;
            assign unused_rnd = rnd;
            assign q          = mag;
        end
    endgenerate

    always_comb begin
        val = neg ? -$signed({1'b0, q}) : $signed({1'b0, q});
        sat = 1'b0;
        y   = val[OUT_W-1:0];
        if (val > MAXV) begin
            sat = 1'b1;
            y   = MAXV[OUT_W-1:0];
        end else if (val < MINV) begin
            sat = 1'b1;
            y   = MINV[OUT_W-1:0];
        end
    end
endmodule

// File: rtl/cmul_pipe.sv
// Pipelined complex multiply by a twiddle (or its conjugate) with rounding and saturation.
// Latency: 3 cycles from input handshake to out_valid.
// Backpressure: all stages stall together while out_valid & ~out_ready; in_ready follows.
module cmul_pipe
    import cmul_pkg::*;
#(
    parameter int IN_W     = 8,
    parameter int IN_FRAC  = 0,
    parameter int TW_W     = 12,
    parameter int TW_FRAC  = 10,
    parameter int OUT_W    = 13,
    parameter int OUT_FRAC = 5
) (
    input logic   clk,
    input logic   rst_n,
    cmul_if.slave io
);
    localparam int PROD_W = prod_w(IN_W, TW_W);
    localparam int SUM_W  = sum_w(IN_W, TW_W);
    localparam int SH     = scale_sh(IN_FRAC, TW_FRAC, OUT_FRAC);

    typedef struct packed {
        logic signed [IN_W-1:0] a;
        logic signed [IN_W-1:0] b;
        logic signed [TW_W-1:0] c;
        logic signed [TW_W:0]   s;
        logic                   rnd;
    } s1_t;

    typedef struct packed {
        logic signed [PROD_W-1:0] p_ac;
        logic signed [PROD_W-1:0] p_bs;
        logic signed [PROD_W-1:0] p_bc;
        logic signed [PROD_W-1:0] p_as;
        logic                     rnd;
    } s2_t;

    logic adv;
    logic v1, v2;
    s1_t  s1, s1_nxt;
    s2_t  s2, s2_nxt;

    logic signed [SUM_W-1:0] sum_re, sum_im;
    logic signed [OUT_W-1:0] y_r, y_i;
    logic                    sat_r, sat_i;

    logic                    out_valid_q;
    logic signed [OUT_W-1:0] out_r_q, out_i_q;
    logic                    sat_q, sticky_q;

    assign adv         = ~out_valid_q | io.out_ready;
    assign io.in_ready = adv;

    always_comb begin
        s1_nxt     = '0;
        s1_nxt.a   = io.in_r;
        s1_nxt.b   = io.in_i;
        s1_nxt.c   = io.cos_tw;
        // Extended by one bit so negating the most negative twiddle stays exact.
        s1_nxt.s   = io.conj_i ? -((TW_W+1)'(io.sin_tw)) : (TW_W+1)'(io.sin_tw);
        s1_nxt.rnd = io.rnd_i;
    end

    // Every product magnitude is at most 2^(PROD_W-2), so PROD_W-bit modular products are exact.
    always_comb begin
        s2_nxt      = '0;
        s2_nxt.p_ac = PROD_W'(s1.a) * PROD_W'(s1.c);
        s2_nxt.p_bs = PROD_W'(s1.b) * PROD_W'(s1.s);
        s2_nxt.p_bc = PROD_W'(s1.b) * PROD_W'(s1.c);
        s2_nxt.p_as = PROD_W'(s1.a) * PROD_W'(s1.s);
        s2_nxt.rnd  = s1.rnd;
    end

    always_comb begin
        sum_re = SUM_W'(s2.p_ac) - SUM_W'(s2.p_bs);
        sum_im = SUM_W'(s2.p_bc) + SUM_W'(s2.p_as);
    end

    cmul_round_sat #(.IN_W(SUM_W), .SH(SH), .OUT_W(OUT_W)) u_rs_re (
        .x   (sum_re),
        .rnd (s2.rnd),
        .y   (y_r),
        .sat (sat_r)
    );

    cmul_round_sat #(.IN_W(SUM_W), .SH(SH), .OUT_W(OUT_W)) u_rs_im (
        .x   (sum_im),
        .rnd (s2.rnd),
        .y   (y_i),
        .sat (sat_i)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1          <= 1'b0;
            v2          <= 1'b0;
            s1          <= '0;
            s2          <= '0;
            out_valid_q <= 1'b0;
            out_r_q     <= '0;
            out_i_q     <= '0;
            sat_q       <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            if (out_valid_q && io.out_ready && sat_q) begin
                sticky_q <= 1'b1;
            end
            if (adv) begin
                v1          <= io.in_valid;
                s1          <= s1_nxt;
                v2          <= v1;
                s2          <= s2_nxt;
                out_valid_q <= v2;
                out_r_q     <= y_r;
                out_i_q     <= y_i;
                sat_q       <= sat_r | sat_i;
            end
        end
    end

    assign io.out_valid  = out_valid_q;
    assign io.out_r      = out_r_q;
    assign io.out_i      = out_i_q;
    assign io.sat_o      = sat_q;
    assign io.sat_sticky = sticky_q;
endmodule
